// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a length-prefixed little-endian byte stream,
// writes 32-bit words into instruction memory from address 0 and holds the core in reset until done.
module imem_loader #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  core_reset,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_WIDTH;

    state_t                state_r;
    state_t                state_s;
    logic [15:0]           len_r;
    logic [15:0]           len_s;
    logic [1:0]            byte_cnt_r;
    logic [1:0]            byte_cnt_s;
    logic [ADDR_WIDTH:0]   word_cnt_r;
    logic [ADDR_WIDTH:0]   word_cnt_s;
    logic [23:0]           word_buf_r;
    logic [23:0]           word_buf_s;
    logic                  in_ready_r;
    logic                  in_ready_s;
    logic                  wr_en_r;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [31:0]           wr_data_r;
    logic [31:0]           wr_data_s;
    logic                  core_reset_r;
    logic                  core_reset_s;
    logic                  done_r;
    logic                  done_s;
    logic                  err_r;
    logic                  err_s;

    logic                  xfer_s;
    logic [15:0]           len_full_s;
    logic                  last_word_s;

    assign xfer_s      = in_valid & in_ready_r;
    assign len_full_s  = {in_data, len_r[7:0]};
    // Word counter is one bit wider than the address so a full-depth load never wraps.
    assign last_word_s = ((16'(word_cnt_r) + 16'd1) == len_r);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_LEN_LO;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LEN_LO: begin
                if (xfer_s) begin
                    state_s = ST_LEN_HI;
                end else begin
                    state_s = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (!xfer_s) begin
                    state_s = ST_LEN_HI;
                end else if (len_full_s == 16'd0) begin
                    state_s = ST_FLUSH;
                end else if ({1'b0, len_full_s} > DEPTH_C) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_s && (byte_cnt_r == 2'd3) && last_word_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_FLUSH: state_s = ST_DONE;
            ST_DONE:  state_s = ST_DONE;
            ST_ERR:   state_s = ST_ERR;
            default:  state_s = ST_LEN_LO;
        endcase
    end

    // Status outputs decoded from the upcoming state, then registered.
    always_comb begin
        in_ready_s   = 1'b0;
        core_reset_s = 1'b1;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: in_ready_s = 1'b1;
            ST_DONE: begin
                core_reset_s = 1'b0;
                done_s       = 1'b1;
            end
            ST_ERR:   err_s = 1'b1;
            ST_FLUSH: in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
    end

    // Length capture, byte lane assembly and write-strobe generation.
    always_comb begin
        len_s      = len_r;
        byte_cnt_s = byte_cnt_r;
        word_cnt_s = word_cnt_r;
        word_buf_s = word_buf_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        case (state_r)
            ST_LEN_LO: begin
                if (xfer_s) begin
                    len_s = {8'h00, in_data};
                end else begin
                    len_s = len_r;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    len_s = len_full_s;
                end else begin
                    len_s = len_r;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    case (byte_cnt_r)
                        2'd0: word_buf_s[7:0]   = in_data;
                        2'd1: word_buf_s[15:8]  = in_data;
                        2'd2: word_buf_s[23:16] = in_data;
                        2'd3: begin
                            wr_en_s    = 1'b1;
                            wr_data_s  = {in_data, word_buf_r};
                            wr_addr_s  = word_cnt_r[ADDR_WIDTH-1:0];
                            word_cnt_s = word_cnt_r + (ADDR_WIDTH+1)'(1);
                        end
                        default: byte_cnt_s = 2'd0;
                    endcase
                end else begin
                    byte_cnt_s = byte_cnt_r;
                end
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    // Datapath and output registers; a reset drops any partially assembled word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            len_r        <= 16'd0;
            byte_cnt_r   <= 2'd0;
            word_cnt_r   <= '0;
            word_buf_r   <= 24'd0;
            in_ready_r   <= 1'b1;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= 32'd0;
            core_reset_r <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            len_r        <= len_s;
            byte_cnt_r   <= byte_cnt_s;
            word_cnt_r   <= word_cnt_s;
            word_buf_r   <= word_buf_s;
            in_ready_r   <= in_ready_s;
            wr_en_r      <= wr_en_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            core_reset_r <= core_reset_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign core_reset = core_reset_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule
